// File: rtl/issue_data_pkg.sv
// issue_data_pkg: shared sizing helper, one-hot AND-OR mux and per-byte
// priority merge for the issue-queue operand data array.
package issue_data_pkg;
    localparam int MAX_SEL = 64;
    localparam int MAX_PORTS = 32;

    function automatic int byte_count(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic onehot_or(input logic [MAX_SEL-1:0] sel, input logic [MAX_SEL-1:0] bits);
        return |(sel & bits);
    endfunction

    // Later ports override earlier ones, so the highest-indexed hit wins.
    function automatic logic [7:0] merge_byte(input logic [7:0] cur, input logic [MAX_PORTS-1:0] hit,
                                              input logic [MAX_PORTS-1:0][7:0] dat);
        logic [7:0] r;
        r = cur;
        for (int p = 0; p < MAX_PORTS; p++) if (hit[p]) r = dat[p];
        return r;
    endfunction
endpackage

// File: rtl/issue_data_entry.sv
// issue_data_entry: one storage entry with byte-granular write merge,
// valid tracking with clear, and same-cycle write-conflict detection.
module issue_data_entry
    import issue_data_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NUM_PORTS = 7,
    localparam int NB = byte_count(DATA_W)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              hit_i,
    input  logic [NUM_PORTS-1:0][NB-1:0]      mask_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  data_i,
    input  logic                              clear_i,
    output logic [DATA_W-1:0]                 data_q_o,
    output logic [DATA_W-1:0]                 data_d_o,
    output logic                              valid_q_o,
    output logic                              valid_d_o,
    output logic                              conflict_q_o
);
    logic [DATA_W-1:0] data_q, data_d;
    logic valid_q, valid_d, conflict_q, conflict_d;
    logic [NB-1:0][MAX_PORTS-1:0] byte_hit;
    logic [NB-1:0][MAX_PORTS-1:0][7:0] byte_dat;

    always_comb begin
        byte_hit = '0;
        byte_dat = '0;
        data_d = data_q;
        for (int b = 0; b < NB; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                byte_hit[b][p] = hit_i[p] & mask_i[p][b];
                byte_dat[b][p] = data_i[p][8*b +: 8];
            end
            data_d[8*b +: 8] = merge_byte(data_q[8*b +: 8], byte_hit[b], byte_dat[b]);
        end
    end

    assign valid_d = |hit_i || (valid_q && !clear_i);
    assign conflict_d = $countones(hit_i) > 1;

    // Storage is deliberately not reset; only the status bits are.
    always_ff @(posedge clock) data_q <= data_d;

    always_ff @(posedge clock) begin
        valid_q <= reset ? 1'b0 : valid_d;
        conflict_q <= reset ? 1'b0 : conflict_d;
    end

    assign data_q_o = data_q;
    assign data_d_o = data_d;
    assign valid_q_o = valid_q;
    assign valid_d_o = valid_d;
    assign conflict_q_o = conflict_q;
endmodule

// File: rtl/issue_data_array_v2.sv
// issue_data_array_v2: one-hot addressed operand data array with byte-masked
// and full-width writes, optional registered read with write forwarding.
module issue_data_array_v2
    import issue_data_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int DATA_W = 64,
    parameter int NUM_READ = 3,
    parameter int NUM_WRITE = 2,
    parameter int NUM_MULTI = 5,
    parameter int READ_LATENCY = 1,
    localparam int NB = byte_count(DATA_W)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_READ*NUM_ENTRIES-1:0]  io_read_addr,
    output logic [NUM_READ*DATA_W-1:0]       io_read_data,
    output logic [NUM_READ-1:0]              io_read_valid,
    input  logic [NUM_WRITE-1:0]             io_write_en,
    input  logic [NUM_WRITE*NB-1:0]          io_write_mask,
    input  logic [NUM_WRITE*NUM_ENTRIES-1:0] io_write_addr,
    input  logic [NUM_WRITE*DATA_W-1:0]      io_write_data,
    input  logic [NUM_MULTI-1:0]             io_multi_en,
    input  logic [NUM_MULTI*NUM_ENTRIES-1:0] io_multi_addr,
    input  logic [NUM_MULTI*DATA_W-1:0]      io_multi_data,
    input  logic [NUM_ENTRIES-1:0]           io_clear,
    output logic                            io_conflict,
    output logic [NUM_ENTRIES-1:0]           io_conflict_vec
);
    localparam int NP = NUM_WRITE + NUM_MULTI;

    logic [NP-1:0] act;
    logic [NP-1:0][NB-1:0] mask;
    logic [NP-1:0][DATA_W-1:0] wdata;
    logic [NP-1:0][NUM_ENTRIES-1:0] waddr;
    logic [NUM_ENTRIES-1:0][DATA_W-1:0] data_q, data_d, src_data;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d, src_valid, conflict_q;
    logic [NUM_READ-1:0][DATA_W-1:0] rd_data;
    logic [NUM_READ-1:0] rd_valid;
    logic [MAX_SEL-1:0] col;

    // Unified port list: normal writes first, then multi-writes (full mask).
    always_comb begin
        act = '0;
        mask = '0;
        wdata = '0;
        waddr = '0;
        for (int p = 0; p < NUM_WRITE; p++) begin
            mask[p] = io_write_mask[p*NB +: NB];
            wdata[p] = io_write_data[p*DATA_W +: DATA_W];
            waddr[p] = io_write_addr[p*NUM_ENTRIES +: NUM_ENTRIES];
            act[p] = io_write_en[p] && |mask[p];
        end
        for (int m = 0; m < NUM_MULTI; m++) begin
            mask[NUM_WRITE+m] = '1;
            wdata[NUM_WRITE+m] = io_multi_data[m*DATA_W +: DATA_W];
            waddr[NUM_WRITE+m] = io_multi_addr[m*NUM_ENTRIES +: NUM_ENTRIES];
            act[NUM_WRITE+m] = io_multi_en[m];
        end
    end

    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
        logic [NP-1:0] hit;
        always_comb begin
            hit = '0;
            for (int p = 0; p < NP; p++) hit[p] = act[p] & waddr[p][e];
        end
        issue_data_entry #(.DATA_W(DATA_W), .NUM_PORTS(NP)) u_entry (
            .clock       (clock),
            .reset       (reset),
            .hit_i       (hit),
            .mask_i      (mask),
            .data_i      (wdata),
            .clear_i     (io_clear[e]),
            .data_q_o    (data_q[e]),
            .data_d_o    (data_d[e]),
            .valid_q_o   (valid_q[e]),
            .valid_d_o   (valid_d[e]),
            .conflict_q_o(conflict_q[e])
        );
    end

    // Registered reads sample next-state so same-cycle writes are forwarded.
    assign src_data = READ_LATENCY == 1 ? data_d : data_q;
    assign src_valid = READ_LATENCY == 1 ? valid_d : valid_q;

    always_comb begin
        rd_data = '0;
        rd_valid = '0;
        col = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            for (int b = 0; b < DATA_W; b++) begin
                for (int i = 0; i < NUM_ENTRIES; i++) col[i] = src_data[i][b];
                rd_data[r][b] = onehot_or(MAX_SEL'(io_read_addr[r*NUM_ENTRIES +: NUM_ENTRIES]), col);
            end
            rd_valid[r] = onehot_or(MAX_SEL'(io_read_addr[r*NUM_ENTRIES +: NUM_ENTRIES]), MAX_SEL'(src_valid));
        end
    end

    if (READ_LATENCY == 1) begin : g_rd_reg
        logic [NUM_READ-1:0][DATA_W-1:0] rd_data_q;
        logic [NUM_READ-1:0] rd_valid_q;
        always_ff @(posedge clock) begin
            rd_data_q <= reset ? '0 : rd_data;
            rd_valid_q <= reset ? '0 : rd_valid;
        end
        assign io_read_data = rd_data_q;
        assign io_read_valid = rd_valid_q;
    end else begin : g_rd_comb
        assign io_read_data = rd_data;
        assign io_read_valid = rd_valid;
    end

    assign io_conflict_vec = conflict_q;
    assign io_conflict = |conflict_q;
endmodule

// File: doc/issue_data_array_v2.md
Name: issue_data_array_v2

Overview:
- Parametrised successor to the issue-queue operand data array: an NUM_ENTRIES x DATA_W register file addressed by one-hot vectors.
- Has normal writes (byte-masked, from dispatch) and multi-writes (full-width, from wakeup/writeback).
- Adds a selectable registered read stage with write-to-read forwarding, per-entry valid tracking with clear, and write-conflict detection.
- Sits inside each reservation station between dispatch/wakeup and the select/issue stage.

Parameters:
- NUM_ENTRIES, 16, entries; width of every one-hot address vector.
- DATA_W, 64, data bits per entry; must be a multiple of 8.
- NUM_READ, 3, read ports.
- NUM_WRITE, 2, byte-masked normal write ports.
- NUM_MULTI, 5, full-width multi-write ports.
- READ_LATENCY, 1, 0 = combinational read, 1 = registered read with forwarding.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- io_read_addr  in  NUM_READ*NUM_ENTRIES  one-hot read vectors, port p at slice [p*NUM_ENTRIES +: NUM_ENTRIES].
- io_read_data  out  NUM_READ*DATA_W  read data.
- io_read_valid  out  NUM_READ  valid bit of the addressed entry (same latency as data).
- io_write_en  in  NUM_WRITE  normal write enables.
- io_write_mask  in  NUM_WRITE*DATA_W/8  byte masks.
- io_write_addr  in  NUM_WRITE*NUM_ENTRIES  one-hot.
- io_write_data  in  NUM_WRITE*DATA_W.
- io_multi_en  in  NUM_MULTI  multi-write enables.
- io_multi_addr  in  NUM_MULTI*NUM_ENTRIES  one-hot.
- io_multi_data  in  NUM_MULTI*DATA_W.
- io_clear  in  NUM_ENTRIES  per-entry valid clear (dealloc).
- io_conflict  out  1  registered: two or more enabled writes hit the same entry last cycle.
- io_conflict_vec  out  NUM_ENTRIES  registered per-entry conflict flags.

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high on `reset`.
- Reset value of every output is 0: all valid bits, the read pipeline registers (READ_LATENCY=1), io_conflict and io_conflict_vec. Data storage is not reset.
- Write ports are ordered with normal writes 0..NUM_WRITE-1 first, then multi-writes 0..NUM_MULTI-1. A normal write with an all-zero mask is treated as disabled.
- Same-entry conflicts resolve per byte: the highest-indexed enabled port whose mask covers that byte wins. Multi-writes cover all bytes, so they override normal writes.
- Any enabled write to an entry sets its valid bit at the next edge.
- io_clear clears valid at the next edge; a clear and a write on the same entry in the same cycle leave valid=1 (write wins). Data is not changed by a clear.
- Read, READ_LATENCY=0: data and valid reflect current storage combinationally; same-cycle writes are not visible.
- Read, READ_LATENCY=1: address is sampled at edge N and data presented in cycle N+1. The sampled value includes the writes committed at edge N (merged per byte under the same priority), so a write in cycle N followed by a read in cycle N is returned in N+1.
- An all-zero read vector returns data 0 and valid 0.
- A read vector with more than one bit set is illegal; the output is then the OR of the selected entries. The bench asserts on it; the RTL does not check it.
- Conflict: io_conflict_vec[i] is registered and set when at least two enabled writes (normal with nonzero mask, or multi) target entry i in the same cycle. It holds for one cycle only. io_conflict is the OR of io_conflict_vec.
- A write vector with multiple bits set writes all selected entries.
- Reset mid-operation: reset overrides the writes of that cycle for valid and conflict state. Storage writes still occur. Read registers are forced to 0.

Decomposition:
- Shared package issue_data_pkg holds:
  - the byte-count function DATA_W/8;
  - a one-hot mux function (AND-OR);
  - a per-byte priority-merge function.
- One sub-module, issue_data_entry: a single entry register with byte-granular merge of all write ports plus its valid/conflict logic. It is instantiated NUM_ENTRIES times.
- The top level handles read muxing and the optional pipeline stage.

Test Plan:
- Reset, then read entry 3 on port 0 (addr 16'h0008) -> io_read_valid[0]=0, io_conflict=0.
- Normal write 0 to entry 5, mask 8'hFF, data 64'h1122_3344_5566_7788, with a read of entry 5 in the same cycle -> next cycle data=64'h1122_3344_5566_7788, valid=1 (forwarding, READ_LATENCY=1).
- Entry 5 holds 64'h1122_3344_5566_7788; write 1 with mask 8'h0F, data 64'hAAAA_AAAA_BBBB_BBBB -> later read returns 64'h1122_3344_BBBB_BBBB.
- Normal write 0 and multi-write 2 both to entry 7 (multi data 64'hDEAD) -> entry 7=64'hDEAD; next cycle io_conflict=1, io_conflict_vec=16'h0080; the cycle after, both return to 0.
- Same-cycle io_clear[9] and multi-write 0 to entry 9 -> valid stays 1. The following cycle, clear alone -> valid=0 while data is unchanged.
- Set READ_LATENCY=0 and write entry 2 while reading entry 2 -> the read returns the old value in the same cycle and the new value in the following cycle.
